// File: rtl/keygen_pkg.sv
// Shared types and constants for the parametrised Galois-LFSR key generator.
package keygen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } keygen_state_e;

  localparam logic [31:0]  POLY_32         = 32'h0040_0006;
  localparam logic [31:0]  DEFAULT_SEED_32 = 32'h0000_0001;
  // x^128 + x^29 + x^27 + x^2 + 1, the tap set of the fixed 128-bit generator
  localparam logic [127:0] LEGACY_POLY_128 = 128'h0000_0000_0000_0000_0000_0000_2800_0004;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/lfsr_galois_step.sv
// One combinational Galois LFSR advance: feedback from the MSB into every tapped bit.
module lfsr_galois_step #(
  parameter int unsigned           WIDTH = 32,
  parameter logic [WIDTH-1:0]      POLY  = 32'h0040_0006
) (
  input  logic [WIDTH-1:0] in_state,
  output logic [WIDTH-1:0] out_state
);

  logic fb;

  always_comb begin
    fb           = in_state[WIDTH-1];
    out_state    = '0;
    out_state[0] = fb;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      out_state[i] = in_state[i-1] ^ (POLY[i] & fb);
    end
  end

endmodule

// File: rtl/lfsr_keygen_param.sv
// Parametrised LFSR key generator with zero-seed protection and a valid/ready key port.
// Optional warm-up phase enabled by defining KEYGEN_WARMUP_EN.
module lfsr_keygen_param
  import keygen_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] POLY         = POLY_32,
  parameter int unsigned      STEP         = 1,
  parameter int unsigned      KEY_W        = 32,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = DEFAULT_SEED_32,
  parameter int unsigned      WARMUP       = 64
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_stop,
  input  logic              in_wr_seed,
  input  logic [WIDTH-1:0]  in_seed,
  input  logic              in_key_ready,
  output logic [WIDTH-1:0]  out_LFSR,
  output logic [KEY_W-1:0]  out_key,
  output logic              out_key_valid,
  output logic              out_seeded,
  output logic              out_seed_err
);

  localparam int unsigned FRESH    = ceil_div(KEY_W, STEP);
  localparam int unsigned FRESH_CW = $clog2(FRESH + 1);
  localparam logic [FRESH_CW-1:0] FRESH_MAX = FRESH_CW'(FRESH);

  keygen_state_e        state;
  logic [WIDTH-1:0]     lfsr;
  logic [FRESH_CW-1:0]  fresh_cnt;
  logic [FRESH_CW-1:0]  fresh_inc;
  logic [WIDTH-1:0]     chain [STEP+1];
  logic                 seed_zero;
  logic                 handshake;
  logic                 advance;

`ifdef KEYGEN_WARMUP_EN
  localparam int unsigned WARM_CW = $clog2(WARMUP + STEP + 1);
  logic [WARM_CW-1:0] warm_cnt;
  logic [WARM_CW-1:0] warm_sum;
  assign warm_sum = warm_cnt + WARM_CW'(STEP);
`endif

  // STEP single advances chained combinationally
  assign chain[0] = lfsr;
  for (genvar g = 0; g < STEP; g++) begin : g_step
    lfsr_galois_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
    ) u_step (
      .in_state  (chain[g]),
      .out_state (chain[g+1])
    );
  end

  assign seed_zero  = (in_seed == '0);
  assign handshake  = out_key_valid & in_key_ready;
  assign advance    = !in_stop && (state != IDLE);
  assign fresh_inc  = fresh_cnt + 1'b1;

  assign out_LFSR   = lfsr;
  assign out_seeded = (state != IDLE);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state         <= IDLE;
      lfsr          <= '0;
      fresh_cnt     <= '0;
      out_key       <= '0;
      out_key_valid <= 1'b0;
      out_seed_err  <= 1'b0;
`ifdef KEYGEN_WARMUP_EN
      warm_cnt      <= '0;
`endif
    end else if (in_wr_seed) begin
      lfsr          <= seed_zero ? DEFAULT_SEED : in_seed;
      out_seed_err  <= seed_zero;
      fresh_cnt     <= '0;
      out_key_valid <= 1'b0;
`ifdef KEYGEN_WARMUP_EN
      warm_cnt      <= '0;
      // A zero-length warm-up would otherwise cost one spurious edge in WARM
      state         <= (WARMUP == 0) ? RUN : WARM;
`else
      state         <= RUN;
`endif
    end else begin
      out_seed_err <= 1'b0;
      if (handshake) begin
        out_key_valid <= 1'b0;
        fresh_cnt     <= '0;
      end
      if (advance) begin
        lfsr <= chain[STEP];
        case (state)
`ifdef KEYGEN_WARMUP_EN
          WARM: begin
            warm_cnt <= warm_sum;
            if (warm_sum >= WARM_CW'(WARMUP)) state <= RUN;
          end
`endif
          RUN: begin
            if (!handshake && (fresh_cnt != FRESH_MAX)) begin
              fresh_cnt <= fresh_inc;
              if ((fresh_inc == FRESH_MAX) && !out_key_valid) begin
                out_key       <= chain[STEP][KEY_W-1:0];
                out_key_valid <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
